servo_pwm_posicao: RTL and testbench
====================================

Name: servo_pwm_posicao

Overview:
Downstream stage of the servo sweep counter. Converts the 3-bit position value from the sweep counter into a standard hobby-servo PWM waveform:
- fixed frame period;
- pulse width = minimum width + position × step.

The position is sampled only at frame boundaries, so pulses are never truncated or glitched. A one-cycle end-of-frame strobe is exported so the upstream counter can advance once per frame through its conta input.

Parameters:
- PERIODO, 1000000: frame length in clock cycles (20 ms at 50 MHz).
- LARGURA_MIN, 50000: pulse width for position 0, in cycles (1 ms).
- PASSO, 7143: extra pulse cycles per position step (position 7 ≈ 2 ms).
- POS_W, 3: width of the position input.
- CNT_W, 20: width of the frame counter and width registers. Must satisfy 2^CNT_W ≥ PERIODO.

Ports:
- clock  input  1  system clock; all state changes on its rising edge.
- zera_as_n  input  1  asynchronous, active-low reset.
- liga  input  1  run enable, level sensitive.
- posicao  input  POS_W  position from the sweep counter (0..7).
- pwm  output  1  servo control pulse, registered.
- fim_periodo  output  1  one-cycle strobe on the last cycle of each frame.
- posicao_atual  output  POS_W  position latched for the current frame.
- ativo  output  1  high while frames are being generated.

Behaviour:
- Reset (zera_as_n=0, takes effect immediately and asynchronously):
  - state PARADO, counter 0, largura_reg 0;
  - pwm=0, fim_periodo=0, posicao_atual=0, ativo=0.
- States:
  - PARADO: counter held at 0, pwm=0, ativo=0.
  - RODANDO: frames generated continuously.
  - ENCERRANDO: liga was dropped mid-frame; the current frame completes.
- PARADO→RODANDO:
  - Occurs on the first edge where liga=1.
  - On that same edge: posicao_atual←posicao, largura_reg←LARGURA_MIN+posicao×PASSO, counter←0.
  - The next cycle is frame cycle 0, with pwm=1 and ativo=1.
- Frame counter:
  - Runs 0..PERIODO-1 in RODANDO and ENCERRANDO, then wraps to 0.
  - pwm=1 exactly on frame cycles 0..largura_reg-1, i.e. largura_reg high cycles per frame.
- Frame boundary (counter=PERIODO-1):
  - fim_periodo=1 for that single cycle.
  - On that edge, posicao_atual and largura_reg reload from the current posicao.
  - posicao changes at any other time have no effect until the next boundary.
- Stopping and restarting:
  - liga=0 in RODANDO → ENCERRANDO. The frame continues unchanged, including fim_periodo.
  - At the boundary in ENCERRANDO with liga still 0 → PARADO. The counter clears and ativo falls on the following cycle.
  - liga=1 again while in ENCERRANDO → RODANDO with no gap; counter and pulse are unaffected.
- Simultaneous events:
  - liga falling on the boundary cycle: the boundary edge reloads position and wraps the counter; the state becomes ENCERRANDO, so one more full frame is emitted.
- Arithmetic:
  - Width is computed in CNT_W bits, unsigned, without saturation.
  - The configuration rule LARGURA_MIN + (2^POS_W - 1)×PASSO < PERIODO is checked by an elaboration-time assertion.
  - Because of this rule, pwm always returns low before the frame ends.
- Reset mid-frame: pwm drops immediately; no partial frame completes.

Decomposition:
- Shared package: state encoding (PARADO, RODANDO, ENCERRANDO) and default timing constants (PERIODO, LARGURA_MIN, PASSO). The upstream sweep counter uses the same timing constants.
- One natural sub-module: contador_periodo, a CNT_W modulo-PERIODO counter with synchronous clear, enable and a terminal-count output.
- The width computation and state machine stay in the top module.

Test Plan (PERIODO=40, LARGURA_MIN=4, PASSO=3, CNT_W=6):
- Reset then liga=1 with posicao=0 → pwm high for 4 cycles out of every 40; fim_periodo pulses every 40 cycles; ativo=1 from the first frame cycle.
- posicao=7 held → pwm high for 25 cycles per frame; posicao_atual=7.
- posicao changed 3→5 at frame cycle 10 → current frame keeps a 13-cycle pulse; the next frame has 19 cycles; posicao_atual updates only after fim_periodo.
- liga dropped at frame cycle 2 → that frame completes with a full pulse and fim_periodo, then pwm=0 and ativo=0; no further pulses.
- liga dropped at cycle 5 and raised again at cycle 20 → frames continue back-to-back with no missing frame.
- zera_as_n asserted at cycle 2 of a pulse → pwm, ativo and posicao_atual go to 0 immediately, without waiting for a clock edge; after release with liga=1, a fresh full frame starts.

Source files
------------

// File: rtl/servo_pwm_posicao_pkg.sv
// Shared definitions for the servo PWM stage and the upstream sweep counter:
// state encoding and default frame timing (50 MHz clock, 20 ms frames).
package servo_pwm_posicao_pkg;

    typedef enum logic [1:0] {
        PARADO     = 2'd0,
        RODANDO    = 2'd1,
        ENCERRANDO = 2'd2
    } estado_t;

    localparam int PERIODO_PADRAO     = 1000000;
    localparam int LARGURA_MIN_PADRAO = 50000;
    localparam int PASSO_PADRAO       = 7143;
    localparam int POS_W_PADRAO       = 3;
    localparam int CNT_W_PADRAO       = 20;

endpackage

// File: rtl/servo_pwm_posicao_contador_periodo.sv
// Modulo-PERIODO frame counter with synchronous clear, enable and a
// terminal-count flag raised on the last cycle of the frame.
module servo_pwm_posicao_contador_periodo
    import servo_pwm_posicao_pkg::*;
#(
    parameter int PERIODO = PERIODO_PADRAO,
    parameter int CNT_W   = CNT_W_PADRAO
) (
    input  logic             clock,
    input  logic             zera_as_n,
    input  logic             limpa,
    input  logic             habilita,
    output logic [CNT_W-1:0] contagem,
    output logic             terminal
);

    localparam logic [CNT_W-1:0] ULTIMO = CNT_W'(PERIODO - 1);

    logic [CNT_W-1:0] contagem_q;
    logic [CNT_W-1:0] contagem_d;

    always_comb begin
        contagem_d = contagem_q;
        if (limpa) begin
            contagem_d = '0;
        end else if (habilita) begin
            contagem_d = (contagem_q == ULTIMO) ? '0 : contagem_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge zera_as_n) begin
        if (!zera_as_n) begin
            contagem_q <= '0;
        end else begin
            contagem_q <= contagem_d;
        end
    end

    assign contagem = contagem_q;
    assign terminal = (contagem_q == ULTIMO);

endmodule

// File: rtl/servo_pwm_posicao.sv
// Hobby-servo PWM generator: fixed frame, pulse width = LARGURA_MIN + posicao*PASSO,
// position sampled only at frame boundaries.
//
// state      | meaning
// PARADO     | idle, counter held at 0, pwm low
// RODANDO    | generating frames continuously
// ENCERRANDO | liga dropped, finishing the current frame
module servo_pwm_posicao
    import servo_pwm_posicao_pkg::*;
#(
    parameter int PERIODO     = PERIODO_PADRAO,
    parameter int LARGURA_MIN = LARGURA_MIN_PADRAO,
    parameter int PASSO       = PASSO_PADRAO,
    parameter int POS_W       = POS_W_PADRAO,
    parameter int CNT_W       = CNT_W_PADRAO
) (
    input  logic             clock,
    input  logic             zera_as_n,
    input  logic             liga,
    input  logic [POS_W-1:0] posicao,
    output logic             pwm,
    output logic             fim_periodo,
    output logic [POS_W-1:0] posicao_atual,
    output logic             ativo
);

    if (LARGURA_MIN + ((2 ** POS_W) - 1) * PASSO >= PERIODO) begin : g_largura_invalida
        $error("servo_pwm_posicao: widest pulse does not fit inside the frame");
    end
    if ((longint'(1) << CNT_W) < longint'(PERIODO)) begin : g_cnt_w_invalida
        $error("servo_pwm_posicao: CNT_W too narrow for PERIODO");
    end

    localparam logic [CNT_W-1:0] MIN_C   = CNT_W'(LARGURA_MIN);
    localparam logic [CNT_W-1:0] PASSO_C = CNT_W'(PASSO);

    estado_t          estado_q;
    estado_t          estado_d;
    logic [POS_W-1:0] posicao_q;
    logic [POS_W-1:0] posicao_d;
    logic [CNT_W-1:0] largura_q;
    logic [CNT_W-1:0] largura_d;
    logic             pwm_q;
    logic             pwm_d;

    logic [CNT_W-1:0] contagem;
    logic [CNT_W-1:0] contagem_prox;
    logic [CNT_W-1:0] largura_nova;
    logic             terminal;
    logic             limpa;
    logic             habilita;

    servo_pwm_posicao_contador_periodo #(
        .PERIODO (PERIODO),
        .CNT_W   (CNT_W)
    ) u_contador_periodo (
        .clock     (clock),
        .zera_as_n (zera_as_n),
        .limpa     (limpa),
        .habilita  (habilita),
        .contagem  (contagem),
        .terminal  (terminal)
    );

    assign largura_nova  = MIN_C + CNT_W'(posicao) * PASSO_C;
    assign contagem_prox = terminal ? '0 : contagem + 1'b1;

    // pwm is registered, so it is decided from the counter value of the next cycle
    always_comb begin
        estado_d  = estado_q;
        posicao_d = posicao_q;
        largura_d = largura_q;
        pwm_d     = 1'b0;
        limpa     = 1'b0;
        habilita  = 1'b0;
        case (estado_q)
            PARADO: begin
                limpa = 1'b1;
                if (liga) begin
                    estado_d  = RODANDO;
                    posicao_d = posicao;
                    largura_d = largura_nova;
                    pwm_d     = (largura_nova != '0);
                end
            end
            RODANDO, ENCERRANDO: begin
                habilita = 1'b1;
                if (terminal) begin
                    posicao_d = posicao;
                    largura_d = largura_nova;
                end
                if (liga) begin
                    estado_d = RODANDO;
                end else if (estado_q == ENCERRANDO && terminal) begin
                    estado_d = PARADO;
                end else begin
                    estado_d = ENCERRANDO;
                end
                pwm_d = (estado_d != PARADO) && (contagem_prox < largura_d);
            end
            default: begin
                estado_d = PARADO;
            end
        endcase
    end

    always_ff @(posedge clock or negedge zera_as_n) begin
        if (!zera_as_n) begin
            estado_q  <= PARADO;
            posicao_q <= '0;
            largura_q <= '0;
            pwm_q     <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            posicao_q <= posicao_d;
            largura_q <= largura_d;
            pwm_q     <= pwm_d;
        end
    end

    assign pwm           = pwm_q;
    assign fim_periodo   = terminal && (estado_q != PARADO);
    assign posicao_atual = posicao_q;
    assign ativo         = (estado_q != PARADO);

endmodule

// File: tb/tb_servo_pwm_posicao.sv
// Directed bench for servo_pwm_posicao with a short frame (40 cycles, widths 4 + 3*pos).
module tb_servo_pwm_posicao;

    logic       clock = 1'b0;
    logic       zera_as_n;
    logic       liga;
    logic [2:0] posicao;
    logic       pwm;
    logic       fim_periodo;
    logic [2:0] posicao_atual;
    logic       ativo;

    int vetores = 0;
    int erros   = 0;

    servo_pwm_posicao #(
        .PERIODO     (40),
        .LARGURA_MIN (4),
        .PASSO       (3),
        .POS_W       (3),
        .CNT_W       (6)
    ) dut (
        .clock         (clock),
        .zera_as_n     (zera_as_n),
        .liga          (liga),
        .posicao       (posicao),
        .pwm           (pwm),
        .fim_periodo   (fim_periodo),
        .posicao_atual (posicao_atual),
        .ativo         (ativo)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        vetores++;
        assert (obs === esp) else begin
            erros++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, esp);
        end
    endtask

    // Runs n cycles, counting high pwm cycles, fim_periodo strobes and inactive cycles
    task automatic ciclos(input int n, output int altos, output int fins, output int inativos);
        altos = 0;
        fins = 0;
        inativos = 0;
        for (int i = 0; i < n; i++) begin
            if (pwm === 1'b1) altos++;
            if (fim_periodo === 1'b1) fins++;
            if (ativo !== 1'b1) inativos++;
            tick();
        end
    endtask

    int a;
    int f;
    int z;
    int a2;
    int f2;
    int z2;

    initial begin
        zera_as_n = 1'b0;
        liga      = 1'b0;
        posicao   = 3'd0;
        #12;
        verifica("reset_pwm", 32'(pwm), 0);
        verifica("reset_ativo", 32'(ativo), 0);
        verifica("reset_fim", 32'(fim_periodo), 0);
        verifica("reset_pos", 32'(posicao_atual), 0);
        zera_as_n = 1'b1;
        tick();
        verifica("idle_ativo", 32'(ativo), 0);

        // start with posicao 0
        liga = 1'b1;
        tick();
        verifica("start_pwm", 32'(pwm), 1);
        verifica("start_ativo", 32'(ativo), 1);
        ciclos(39, a, f, z);
        verifica("p0_fim_cyc39", 32'(fim_periodo), 1);
        ciclos(1, a2, f2, z2);
        verifica("p0_altos", 32'(a + a2), 4);
        verifica("p0_fins", 32'(f + f2), 1);
        verifica("p0_inativos", 32'(z + z2), 0);

        // posicao 7: old width kept for this frame, 25 cycles afterwards
        posicao = 3'd7;
        ciclos(40, a, f, z);
        verifica("p7_prev_altos", 32'(a), 4);
        verifica("p7_pos_atual", 32'(posicao_atual), 7);
        ciclos(40, a, f, z);
        verifica("p7_altos", 32'(a), 25);
        verifica("p7_fins", 32'(f), 1);

        // 3 then changed to 5 at frame cycle 10
        posicao = 3'd3;
        ciclos(40, a, f, z);
        verifica("p3_prev_altos", 32'(a), 25);
        ciclos(10, a, f, z);
        verifica("p3_pos_atual", 32'(posicao_atual), 3);
        posicao = 3'd5;
        ciclos(29, a2, f2, z2);
        verifica("p3_pos_cyc39", 32'(posicao_atual), 3);
        verifica("p3_fim_cyc39", 32'(fim_periodo), 1);
        a = a + a2;
        f = f + f2;
        ciclos(1, a2, f2, z2);
        verifica("p3_altos", 32'(a + a2), 13);
        verifica("p3_fins", 32'(f + f2), 1);
        verifica("p5_pos_atual", 32'(posicao_atual), 5);
        ciclos(40, a, f, z);
        verifica("p5_altos", 32'(a), 19);

        // liga dropped at frame cycle 2: frame completes, then stop
        ciclos(2, a, f, z);
        liga = 1'b0;
        ciclos(38, a2, f2, z2);
        verifica("stop_altos", 32'(a + a2), 19);
        verifica("stop_fins", 32'(f + f2), 1);
        verifica("stop_pwm", 32'(pwm), 0);
        verifica("stop_ativo", 32'(ativo), 0);
        ciclos(80, a, f, z);
        verifica("idle_altos", 32'(a), 0);
        verifica("idle_fins", 32'(f), 0);
        verifica("idle_inativos", 32'(z), 80);

        // restart; liga dropped at cycle 5 and raised at 20
        liga = 1'b1;
        tick();
        verifica("restart_pwm", 32'(pwm), 1);
        ciclos(5, a, f, z);
        liga = 1'b0;
        ciclos(15, a2, f2, z2);
        a = a + a2;
        f = f + f2;
        z = z + z2;
        liga = 1'b1;
        ciclos(20, a2, f2, z2);
        verifica("gap_altos", 32'(a + a2), 19);
        verifica("gap_fins", 32'(f + f2), 1);
        verifica("gap_inativos", 32'(z + z2), 0);
        ciclos(40, a, f, z);
        verifica("gap_next_altos", 32'(a), 19);
        verifica("gap_next_inativos", 32'(z), 0);

        // liga falling exactly on the boundary cycle: one more full frame
        ciclos(39, a, f, z);
        liga = 1'b0;
        ciclos(1, a2, f2, z2);
        verifica("edge_ativo", 32'(ativo), 1);
        verifica("edge_pwm", 32'(pwm), 1);
        ciclos(40, a, f, z);
        verifica("edge_altos", 32'(a), 19);
        verifica("edge_fins", 32'(f), 1);
        verifica("edge_end_ativo", 32'(ativo), 0);

        // asynchronous reset in the middle of a pulse
        posicao = 3'd7;
        liga = 1'b1;
        tick();
        ciclos(2, a, f, z);
        verifica("pre_rst_pwm", 32'(pwm), 1);
        #2;
        zera_as_n = 1'b0;
        #1;
        verifica("async_pwm", 32'(pwm), 0);
        verifica("async_ativo", 32'(ativo), 0);
        verifica("async_pos", 32'(posicao_atual), 0);
        tick();
        tick();
        zera_as_n = 1'b1;
        tick();
        verifica("post_rst_pwm", 32'(pwm), 1);
        verifica("post_rst_pos", 32'(posicao_atual), 7);
        ciclos(40, a, f, z);
        verifica("post_rst_altos", 32'(a), 25);
        verifica("post_rst_fins", 32'(f), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vetores, erros);
        $finish;
    end

endmodule
